mem_rr_scheduler: RTL and testbench

- Work-conserving round-robin scheduler that shares one single-port RAM between CORE_NUM cores.
- Unlike a fixed-slot poller, it skips idle cores and grants the next requester immediately.
- Holds the RAM for a programmable access latency, then returns read data and a one-cycle response pulse to the served core.
- Sits between the core memory ports and the shared RAM instance.

---
 rtl/mem_rr_scheduler.sv | 131 +++++++++++++
 tb/tb_mem_rr_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_scheduler.sv
// Work-conserving round-robin arbiter sharing one single-port RAM between CORE_NUM cores.
// state  | meaning
// IDLE   | waiting for any request; arbitration happens here
// ACCESS | RAM owned by grant_id for RD_LATENCY cycles
// RESP   | one-cycle response pulse to the served core
module mem_rr_scheduler #(
  parameter int WIDTH      = 32,
  parameter int CORE_NUM   = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CORE_NUM-1:0]           request,
  input  logic [CORE_NUM-1:0]           wren_core,
  input  logic [CORE_NUM*WIDTH-1:0]     address_in,
  input  logic [CORE_NUM*WIDTH-1:0]     data_in,
  output logic [CORE_NUM*WIDTH-1:0]     data_out,
  output logic [CORE_NUM-1:0]           response,
  output logic [WIDTH-1:0]              address,
  output logic [WIDTH-1:0]              data_write,
  output logic                          wren,
  input  logic [WIDTH-1:0]              data_read,
  output logic [$clog2(CORE_NUM)-1:0]   grant_id,
  output logic                          busy
);

  localparam int IDW  = $clog2(CORE_NUM);
  localparam int CNTW = $clog2(RD_LATENCY) + 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_next;
  logic [IDW-1:0]  last_grant;
  logic [CNTW-1:0] cnt;
  logic            wr_op;

  logic [IDW-1:0]   pick, idx;
  logic             pick_valid;
  logic [WIDTH-1:0] pick_addr, pick_data;
  logic             pick_wr;

  // Search downward so the closest core after last_grant is the final winner.
  always_comb begin
    pick       = last_grant;
    pick_valid = 1'b0;
    idx        = '0;
    for (int k = CORE_NUM; k >= 1; k--) begin
      idx = last_grant + IDW'(k);
      if (request[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
    pick_addr = '0;
    pick_data = '0;
    pick_wr   = 1'b0;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (IDW'(i) == pick) begin
        pick_addr = address_in[i*WIDTH +: WIDTH];
        pick_data = data_in[i*WIDTH +: WIDTH];
        pick_wr   = wren_core[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = ACCESS;
      ACCESS:  if (cnt == LAST) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= '1;
      cnt        <= '0;
      wr_op      <= 1'b0;
      data_out   <= '0;
      response   <= '0;
      address    <= '0;
      data_write <= '0;
      wren       <= 1'b0;
      grant_id   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            address    <= pick_addr;
            grant_id   <= pick;
            last_grant <= pick;
            busy       <= 1'b1;
            cnt        <= '0;
            wr_op      <= pick_wr;
            if (pick_wr) begin
              data_write <= pick_data;
              wren       <= 1'b1;
            end
          end
        end
        ACCESS: begin
          wren <= 1'b0;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            for (int i = 0; i < CORE_NUM; i++) begin
              if (IDW'(i) == grant_id) begin
                response[i] <= 1'b1;
                if (!wr_op) data_out[i*WIDTH +: WIDTH] <= data_read;
              end
            end
          end
        end
        RESP: begin
          response <= '0;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Bench for mem_rr_scheduler: directed scenarios plus random traffic, checked every cycle
// against a transaction-timeline model (grant edge t0, response at t0+RD_LATENCY).
module tb_mem_rr_scheduler;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]   request = '0, wren_core = '0;
  logic [N*W-1:0] address_in = '0, data_in = '0;
  logic [N*W-1:0] data_out;
  logic [N-1:0]   response;
  logic [W-1:0]   address, data_write, data_read;
  logic           wren, busy;
  logic [1:0]     grant_id;

  mem_rr_scheduler #(.WIDTH(W), .CORE_NUM(N), .RD_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .request(request), .wren_core(wren_core),
    .address_in(address_in), .data_in(data_in), .data_out(data_out),
    .response(response), .address(address), .data_write(data_write),
    .wren(wren), .data_read(data_read), .grant_id(grant_id), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  function automatic logic [W-1:0] ram_init(int i);
    return 32'h5A00_0000 | (i * 32'h0001_0203);
  endfunction

  // Environment RAM: data only valid on the last access cycle, garbage otherwise.
  logic [W-1:0] ram [256];
  int ram_age = 0;
  always @(posedge clk) begin
    if (wren) ram[address[7:0]] = data_write;
    if (reset || !busy) ram_age = 0;
    else                ram_age = ram_age + 1;
  end
  assign data_read = (busy && ram_age == L-1) ? ram[address[7:0]] : {16'hBAD0, cyc[15:0]};

  // Reference model: one transaction at a time, positioned by its grant cycle.
  logic [W-1:0] m_mem [256];
  logic [W-1:0] e_dout [N];
  logic [W-1:0] e_addr, e_dw;
  logic [N-1:0] e_resp;
  logic [1:0]   e_gid;
  logic         e_wren, e_busy;
  bit m_active = 0, m_wr = 0;
  int m_last = N-1, m_t0 = 0, m_g = 0, age;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      m_active = 0; m_last = N-1;
      e_addr = '0; e_dw = '0; e_wren = 0; e_gid = '0; e_busy = 0; e_resp = '0;
      for (int i = 0; i < N; i++) e_dout[i] = '0;
    end else if (!m_active) begin
      if (request != '0) begin
        int g;
        g = 0;
        for (int k = 1; k <= N; k++) begin
          if (request[(m_last + k) % N]) begin g = (m_last + k) % N; break; end
        end
        m_active = 1; m_t0 = cyc; m_g = g; m_last = g;
        e_addr = address_in[g*W +: W]; e_gid = 2'(g); e_busy = 1; m_wr = wren_core[g];
        if (m_wr) begin
          e_dw = data_in[g*W +: W]; e_wren = 1;
          m_mem[e_addr[7:0]] = e_dw;
        end
      end
    end else begin
      age = cyc - m_t0;
      e_wren = 0;
      if (age == L) begin
        e_resp[m_g] = 1'b1;
        if (!m_wr) e_dout[m_g] = m_mem[e_addr[7:0]];
      end else if (age == L+1) begin
        e_resp = '0; e_busy = 0; m_active = 0;
      end
    end
  end

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  bit chk_en = 0;
  logic busy_q = 0;
  logic [N-1:0] resp_neg = '0;
  int g_log[$], gc_log[$], r_log[$], rc_log[$];
  int wren_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N*W-1:0] exp_do;
      for (int i = 0; i < N; i++) exp_do[i*W +: W] = e_dout[i];
      chk("data_out", data_out, exp_do);
      chk("response", response, e_resp);
      chk("busy", busy, e_busy);
      chk("grant_id", grant_id, e_gid);
      chk("address", address, e_addr);
      chk("wren", wren, e_wren);
      chk("data_write", data_write, e_dw);
      if (busy && !busy_q) begin g_log.push_back(int'(grant_id)); gc_log.push_back(cyc); end
      if (response != '0) begin r_log.push_back(int'(response)); rc_log.push_back(cyc); end
      if (wren) wren_cnt++;
    end
    busy_q   = busy;
    resp_neg = response;
  end

  function automatic int qg(int q[$], int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  logic [N-1:0] sticky = '0;
  bit rnd_en = 0;

  task automatic raise(int c, logic wr, logic [W-1:0] a, logic [W-1:0] d);
    request[c] = 1'b1; wren_core[c] = wr;
    address_in[c*W +: W] = a; data_in[c*W +: W] = d;
  endtask

  // Core behaviour: drop request on the edge at which response was seen.
  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (resp_neg[i]) request[i] = sticky[i];
      if (rnd_en && !request[i] && $urandom_range(0, 3) == 0)
        raise(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
  endtask

  task automatic run_until_idle(int max);
    int n;
    n = 0;
    do begin step(); n++; end while (!(request == '0 && !busy) && n < max);
    if (n >= max) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: still busy after %0d cycles, required idle", max);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; request = '0; wren_core = '0; sticky = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_logs();
    g_log.delete(); gc_log.delete(); r_log.delete(); rc_log.delete(); wren_cnt = 0;
  endtask

  int r;

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = ram_init(i); m_mem[i] = ram_init(i); end
    ram[8'h10] = 32'hCAFEBABE; m_mem[8'h10] = 32'hCAFEBABE;
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_grant", grant_id, 0);

    // 1: core2 read
    clear_logs(); raise(2, 0, 32'h10, 0); r = cyc;
    run_until_idle(30);
    chk("t1_grant", qg(g_log, 0), 2);
    chk("t1_resp_lat", qg(rc_log, 0) - r, L+1);
    chk("t1_resp_val", qg(r_log, 0), 4'b0100);
    chk("t1_resp_cnt", r_log.size(), 1);
    chk("t1_data", data_out[2*W +: W], 32'hCAFEBABE);
    chk("t1_wren_cnt", wren_cnt, 0);

    // 2: all four at once
    do_reset(); clear_logs();
    for (int i = 0; i < N; i++) raise(i, 0, 32'h40 + i, 0);
    run_until_idle(60);
    for (int i = 0; i < N; i++) chk("t2_order", qg(g_log, i), i);
    for (int i = 1; i < N; i++) chk("t2_spacing", qg(gc_log, i) - qg(gc_log, i-1), L+2);
    chk("t2_resp_cnt", r_log.size(), N);

    // 3: cores 0 and 1 continuously
    do_reset(); clear_logs(); sticky = 4'b0011;
    raise(0, 0, 32'h60, 0); raise(1, 0, 32'h61, 0);
    repeat (6*(L+2) + 2) step();
    sticky = '0;
    run_until_idle(30);
    for (int i = 0; i < 6; i++) chk("t3_alternate", qg(g_log, i), i % 2);

    // 4: core3 write
    do_reset(); clear_logs();
    raise(3, 1, 32'h20, 32'hDEADBEEF);
    run_until_idle(30);
    chk("t4_wren_cnt", wren_cnt, 1);
    chk("t4_ram", ram[8'h20], 32'hDEADBEEF);
    chk("t4_data_out", data_out[3*W +: W], 0);
    chk("t4_resp", qg(r_log, 0), 4'b1000);

    // 5: last_grant=3, only core1
    clear_logs(); raise(1, 0, 32'h30, 0); r = cyc;
    run_until_idle(30);
    chk("t5_grant", qg(g_log, 0), 1);
    chk("t5_grant_lat", qg(gc_log, 0) - r, 1);

    // 6: reset in second ACCESS cycle
    do_reset(); clear_logs();
    raise(0, 0, 32'h50, 0);
    step(); step();
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_resp", response, 0);
    chk("t6_addr", address, 0);
    chk("t6_no_resp", r_log.size(), 0);
    run_until_idle(30);
    chk("t6_resp_cnt", r_log.size(), 1);
    chk("t6_data", data_out[0 +: W], ram_init(8'h50));

    // random traffic
    do_reset(); clear_logs(); rnd_en = 1;
    repeat (2000) step();
    rnd_en = 0;
    run_until_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
